ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Multi-cycle multiply/divide unit with HI/LO registers, instantiated beside the ALU in the EX stage.
//  Operands arrive already forwarded. Stall request goes to the hazard unit.
//  MFHI/MFLO results return to the EX result mux.
// PARAMETERS
//  DATA_W   32  operand, HI and LO width
//  MULT_LAT 5   cycles busy for MULT/MULTU (and MADD* ops); must be >=1
//  DIV_LAT  10  cycles busy for DIV/DIVU; must be >=1
//  CNT_W    4   latency counter width; must hold max(MULT_LAT,DIV_LAT)
// PORTS
//  clk       in  1       rising-edge clock
//  reset     in  1       asynchronous, active-low; 0 = reset
//  md_valid  in  1       EX holds a valid instruction for this unit
//  md_op     in  4       op code (`MD_* in MD_Param.v)
//  flush     in  1       EX instruction squashed this cycle
//  rs_data   in  DATA_W  forwarded rs value
//  rt_data   in  DATA_W  forwarded rt value
//  busy      out 1       operation in flight
//  stall_req out 1       hold ID/EX; =busy & md_valid & (md_op!=`MD_NONE), combinational
//  md_rdata  out DATA_W  HI for MFHI, LO for MFLO, else 0; combinational
//  hi_q      out DATA_W  architectural HI (debug/trace)
//  lo_q      out DATA_W  architectural LO (debug/trace)
// BEHAVIOUR
//  - Reset (async, reset==0): state IDLE, cnt=0, busy=0, hi_q=lo_q=0, staged result=0.
//  - FSM IDLE/BUSY. Issue condition: IDLE & md_valid & !flush & op in {MULT,MULTU,DIV,DIVU[,MADD*]}.
//  - On issue edge:
//    - compute result from the current operands via md_arith; latch it into res_hi/res_lo.
//    - cnt=LAT-1; state BUSY.
//    - busy=1 from the next cycle.
//  - BUSY: cnt decrements each edge. On the edge where cnt==0, hi_q/lo_q<=res, state IDLE.
//    - Net effect: busy high exactly LAT cycles; new HI/LO readable the cycle busy falls.
//  - MTHI/MTLO: accepted when IDLE & md_valid & !flush; hi_q/lo_q<=rs_data on next edge.
//  - MFHI/MFLO: md_rdata valid only when stall_req==0.
//  - Any md op while BUSY: stall_req=1, op not executed; the pipeline re-presents it.
//  - MULT: signed DATA_W x DATA_W -> 2*DATA_W product, {hi,lo}. MULTU: unsigned.
//  - DIV: signed truncating division.
//    - lo=quotient; hi=remainder, sign follows dividend.
//    - -7/2 -> lo=-3, hi=-1.
//    - INT_MIN/-1 -> lo=INT_MIN, hi=0.
//  - DIVU: unsigned. Divisor 0 (DIV or DIVU): op occupies DIV_LAT, HI/LO unchanged at completion.
//  - Flush:
//    - issue cycle: nothing issued.
//    - while BUSY: abort; state IDLE next edge, HI/LO unchanged, busy=0 next cycle.
//  - Reset mid-operation: immediate return to reset values; result discarded.
//  - md_op unknown or `MD_NONE: no state change.
// CONFIGURATION
//  - `MD_MADD_EN defined: MADD/MADDU/MSUB/MSUBU (signed/unsigned).
//    - {hi,lo} +/- rs*rt, modulo 2^(2*DATA_W), using HI/LO sampled at issue.
//    - latency MULT_LAT.
//  - `MD_MADD_EN undefined: those four codes treated as `MD_NONE.
//    - no busy, no HI/LO change, stall_req=0.
// STRUCTURE
//  - MD_Param.v (shared header): `MD_NONE, `MD_MULT, `MD_MULTU, `MD_DIV, `MD_DIVU,
//    `MD_MFHI, `MD_MFLO, `MD_MTHI, `MD_MTLO, `MD_MADD, `MD_MADDU, `MD_MSUB, `MD_MSUBU (4-bit).
//  - Also in MD_Param.v: FSM state codes.
//  - Sub-module md_arith: combinational.
//    - inputs: op, rs, rt, hi, lo.
//    - outputs: res_hi, res_lo, div0 flag.
//  - Top: FSM, counter, HI/LO and staged-result registers, stall/read logic.
// TESTING
//  - MULT -3 x 5, MULT_LAT=5:
//    - busy 1 for 5 cycles.
//    - then hi=FFFFFFFF, lo=FFFFFFF1.
//    - MFHI issued during busy stalls until busy=0.
//  - DIVU 100/7: after 10 cycles lo=14, hi=2.
//  - DIV -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF.
//  - DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
//  - DIV x/0 -> HI/LO unchanged.
//  - MTHI 1234 then MULT, flush raised at busy cycle 2:
//    - busy drops next cycle; hi=1234 retained.
//    - following MFHI returns 1234.
//  - Assert reset mid-DIV at cycle 4:
//    - busy, hi_q, lo_q =0 immediately.
//    - after release, DIVU 9/3 completes normally (lo=3, hi=0).
//  - With `MD_MADD_EN:
//    - hi=0, lo=FFFFFFFF, MADDU 1x1 -> hi=1, lo=0.
//    - without the macro, same stimulus: busy stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// ex_muldiv_unit_pkg
//   Shared definitions for the EX-stage multiply/divide unit: 4-bit op codes,
//   FSM state type and small op-classification helpers.
//
//   Configuration macro: MD_MADD_EN
//     defined   : MADD/MADDU/MSUB/MSUBU are real multi-cycle ops.
//     undefined : those four codes behave exactly like MD_NONE.
// -----------------------------------------------------------------------------
package ex_muldiv_unit_pkg;

   localparam logic [3:0] MD_NONE  = 4'd0;
   localparam logic [3:0] MD_MULT  = 4'd1;
   localparam logic [3:0] MD_MULTU = 4'd2;
   localparam logic [3:0] MD_DIV   = 4'd3;
   localparam logic [3:0] MD_DIVU  = 4'd4;
   localparam logic [3:0] MD_MFHI  = 4'd5;
   localparam logic [3:0] MD_MFLO  = 4'd6;
   localparam logic [3:0] MD_MTHI  = 4'd7;
   localparam logic [3:0] MD_MTLO  = 4'd8;
   localparam logic [3:0] MD_MADD  = 4'd9;
   localparam logic [3:0] MD_MADDU = 4'd10;
   localparam logic [3:0] MD_MSUB  = 4'd11;
   localparam logic [3:0] MD_MSUBU = 4'd12;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StBusy = 1'b1
   } md_state_e;

   function automatic logic md_madd_enabled();
`ifdef MD_MADD_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic md_is_madd(input logic [3:0] op);
      return (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
   endfunction

   function automatic logic md_is_div(input logic [3:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   // Ops that occupy the unit for a latency period.
   function automatic logic md_is_long(input logic [3:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || md_is_div(op) ||
             (md_is_madd(op) && md_madd_enabled());
   endfunction

   // Any op this unit actually services; MD_NONE, unknown codes and disabled
   // MADD-family codes are excluded so they never raise a stall.
   function automatic logic md_is_known(input logic [3:0] op);
      return md_is_long(op) || (op == MD_MFHI) || (op == MD_MFLO) ||
             (op == MD_MTHI) || (op == MD_MTLO);
   endfunction

endpackage

// File: rtl/md_arith.sv
// -----------------------------------------------------------------------------
// md_arith
//   Purely combinational arithmetic core of the multiply/divide unit.
//   Ports:
//     op      in  4       operation code
//     rs, rt  in  DATA_W  operands (rs = dividend / multiplicand)
//     hi, lo  in  DATA_W  current HI/LO (accumulator for MADD-family ops)
//     res_hi  out DATA_W  result for HI
//     res_lo  out DATA_W  result for LO
//     div0    out 1       DIV/DIVU with a zero divisor
// -----------------------------------------------------------------------------
module md_arith
   import ex_muldiv_unit_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] rs,
   input  logic [DATA_W-1:0] rt,
   input  logic [DATA_W-1:0] hi,
   input  logic [DATA_W-1:0] lo,
   output logic [DATA_W-1:0] res_hi,
   output logic [DATA_W-1:0] res_lo,
   output logic              div0
);

   localparam int unsigned PW = 2 * DATA_W;

   logic signed [PW-1:0] rs_sx;
   logic signed [PW-1:0] rt_sx;
   logic [PW-1:0]        prod_s;
   logic [PW-1:0]        prod_u;
   logic [PW-1:0]        acc;

   assign rs_sx  = signed'({{DATA_W{rs[DATA_W-1]}}, rs});
   assign rt_sx  = signed'({{DATA_W{rt[DATA_W-1]}}, rt});
   // Low PW bits of the sign-extended product are the exact signed product.
   assign prod_s = unsigned'(rs_sx * rt_sx);
   assign prod_u = {{DATA_W{1'b0}}, rs} * {{DATA_W{1'b0}}, rt};
   assign acc    = {hi, lo};

   // Shared unsigned divider; signed division runs on magnitudes and fixes
   // the signs afterwards, which also makes INT_MIN / -1 wrap to INT_MIN.
   logic              is_signed_div;
   logic              rs_neg;
   logic              rt_neg;
   logic [DATA_W-1:0] dividend;
   logic [DATA_W-1:0] divisor;
   logic [DATA_W-1:0] divisor_safe;
   logic [DATA_W-1:0] quo_u;
   logic [DATA_W-1:0] rem_u;
   logic [DATA_W-1:0] quo_s;
   logic [DATA_W-1:0] rem_s;

   assign is_signed_div = (op == MD_DIV);
   assign rs_neg        = is_signed_div & rs[DATA_W-1];
   assign rt_neg        = is_signed_div & rt[DATA_W-1];
   assign dividend      = rs_neg ? (~rs + DATA_W'(1)) : rs;
   assign divisor       = rt_neg ? (~rt + DATA_W'(1)) : rt;
   // Avoid a divide-by-zero in the datapath; the result is discarded anyway.
   assign divisor_safe  = (divisor == '0) ? DATA_W'(1) : divisor;
   assign quo_u         = dividend / divisor_safe;
   assign rem_u         = dividend % divisor_safe;
   assign quo_s         = (rs_neg ^ rt_neg) ? (~quo_u + DATA_W'(1)) : quo_u;
   assign rem_s         = rs_neg ? (~rem_u + DATA_W'(1)) : rem_u;

   assign div0 = md_is_div(op) && (rt == '0);

   always_comb begin
      res_hi = '0;
      res_lo = '0;
      case (op)
         MD_MULT:  {res_hi, res_lo} = prod_s;
         MD_MULTU: {res_hi, res_lo} = prod_u;
         MD_DIV: begin
            res_hi = rem_s;
            res_lo = quo_s;
         end
         MD_DIVU: begin
            res_hi = rem_u;
            res_lo = quo_u;
         end
         MD_MADD:  {res_hi, res_lo} = acc + prod_s;
         MD_MADDU: {res_hi, res_lo} = acc + prod_u;
         MD_MSUB:  {res_hi, res_lo} = acc - prod_s;
         MD_MSUBU: {res_hi, res_lo} = acc - prod_u;
         default: begin
            res_hi = '0;
            res_lo = '0;
         end
      endcase
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// -----------------------------------------------------------------------------
// ex_muldiv_unit
//   Multi-cycle multiply/divide unit with HI/LO registers, sitting beside the
//   ALU in the EX stage. Operands arrive already forwarded.
//   Ports:
//     clk        in  1       rising-edge clock
//     reset      in  1       asynchronous, active-low
//     md_valid   in  1       EX holds a valid instruction for this unit
//     md_op      in  4       op code (MD_* in ex_muldiv_unit_pkg)
//     flush      in  1       EX instruction squashed this cycle
//     rs_data    in  DATA_W  forwarded rs value
//     rt_data    in  DATA_W  forwarded rt value
//     busy       out 1       operation in flight
//     stall_req  out 1       hold ID/EX while busy and an md op is presented
//     md_rdata   out DATA_W  HI for MFHI, LO for MFLO, else 0
//     hi_q, lo_q out DATA_W  architectural HI/LO
//   Configuration macro: MD_MADD_EN (enables MADD/MADDU/MSUB/MSUBU).
// -----------------------------------------------------------------------------
module ex_muldiv_unit
   import ex_muldiv_unit_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10,
   parameter int unsigned CNT_W    = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              md_valid,
   input  logic [3:0]        md_op,
   input  logic              flush,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   output logic              busy,
   output logic              stall_req,
   output logic [DATA_W-1:0] md_rdata,
   output logic [DATA_W-1:0] hi_q,
   output logic [DATA_W-1:0] lo_q
);

   localparam logic [CNT_W-1:0] MultCnt = CNT_W'(MULT_LAT - 1);
   localparam logic [CNT_W-1:0] DivCnt  = CNT_W'(DIV_LAT - 1);

   md_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] hi_d, lo_d;
   logic [DATA_W-1:0] res_hi_q, res_hi_d;
   logic [DATA_W-1:0] res_lo_q, res_lo_d;
   logic              res_div0_q, res_div0_d;

   logic [DATA_W-1:0] arith_hi;
   logic [DATA_W-1:0] arith_lo;
   logic              arith_div0;
   logic              accept;

   md_arith #(
      .DATA_W (DATA_W)
   ) u_md_arith (
      .op     (md_op),
      .rs     (rs_data),
      .rt     (rt_data),
      .hi     (hi_q),
      .lo     (lo_q),
      .res_hi (arith_hi),
      .res_lo (arith_lo),
      .div0   (arith_div0)
   );

   assign accept    = (state_q == StIdle) && md_valid && !flush;
   assign busy      = (state_q == StBusy);
   assign stall_req = busy && md_valid && md_is_known(md_op);

   // Next-state, counter, HI/LO and staged-result update.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      res_hi_d   = res_hi_q;
      res_lo_d   = res_lo_q;
      res_div0_d = res_div0_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               if (md_is_long(md_op)) begin
                  state_d    = StBusy;
                  cnt_d      = md_is_div(md_op) ? DivCnt : MultCnt;
                  res_hi_d   = arith_hi;
                  res_lo_d   = arith_lo;
                  res_div0_d = arith_div0;
               end else if (md_op == MD_MTHI) begin
                  hi_d = rs_data;
               end else if (md_op == MD_MTLO) begin
                  lo_d = rs_data;
               end
            end
         end
         StBusy: begin
            if (flush) begin
               // Squashed op: abandon the staged result.
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = StIdle;
               // Divide-by-zero still takes the full latency but leaves HI/LO alone.
               if (!res_div0_q) begin
                  hi_d = res_hi_q;
                  lo_d = res_lo_q;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         res_hi_q   <= '0;
         res_lo_q   <= '0;
         res_div0_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         res_hi_q   <= res_hi_d;
         res_lo_q   <= res_lo_d;
         res_div0_q <= res_div0_d;
      end
   end

   // Move-from result; meaningful only when not stalled.
   always_comb begin
      md_rdata = '0;
      if (!stall_req) begin
         if (md_op == MD_MFHI) begin
            md_rdata = hi_q;
         end else if (md_op == MD_MFLO) begin
            md_rdata = lo_q;
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
   import ex_muldiv_unit_pkg::*;

   localparam int ML = 5;
   localparam int DL = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        md_valid;
   logic [3:0]  md_op;
   logic        flush;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        busy;
   logic        stall_req;
   logic [31:0] md_rdata;
   logic [31:0] hi_q;
   logic [31:0] lo_q;

   int total = 0;
   int bad   = 0;

   // Reference HI/LO.
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   always #5 clk = ~clk;

   ex_muldiv_unit #(
      .DATA_W   (32),
      .MULT_LAT (ML),
      .DIV_LAT  (DL),
      .CNT_W    (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .md_valid  (md_valid),
      .md_op     (md_op),
      .flush     (flush),
      .rs_data   (rs_data),
      .rt_data   (rt_data),
      .busy      (busy),
      .stall_req (stall_req),
      .md_rdata  (md_rdata),
      .hi_q      (hi_q),
      .lo_q      (lo_q)
   );

   // Architectural effect of one op on the reference HI/LO; returns busy cycles.
   function automatic int model_apply(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] p, qv, rv;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         MD_MULT: begin
            p = sa * sb;
            {m_hi, m_lo} = p;
            return ML;
         end
         MD_MULTU: begin
            p = {32'd0, a} * {32'd0, b};
            {m_hi, m_lo} = p;
            return ML;
         end
         MD_DIV: begin
            if (b != 0) begin
               q = sa / sb;
               r = sa % sb;
               qv = q;
               rv = r;
               m_lo = qv[31:0];
               m_hi = rv[31:0];
            end
            return DL;
         end
         MD_DIVU: begin
            if (b != 0) begin
               m_lo = a / b;
               m_hi = a % b;
            end
            return DL;
         end
         MD_MTHI: m_hi = a;
         MD_MTLO: m_lo = a;
`ifdef MD_MADD_EN
         MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: begin
            p = (op == MD_MADD || op == MD_MSUB) ? 64'(sa * sb) : ({32'd0, a} * {32'd0, b});
            if (op == MD_MADD || op == MD_MADDU) {m_hi, m_lo} = {m_hi, m_lo} + p;
            else {m_hi, m_lo} = {m_hi, m_lo} - p;
            return ML;
         end
`endif
         default: ;
      endcase
      return 0;
   endfunction

   // Present one op for one edge, then count cycles with busy high (bounded).
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cyc);
      md_valid = 1'b1;
      md_op    = op;
      rs_data  = a;
      rt_data  = b;
      @(posedge clk);
      #1;
      md_valid = 1'b0;
      md_op    = MD_NONE;
      cyc = 0;
      while (busy && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic test_reset();
      reset    = 1'b0;
      md_valid = 1'b0;
      md_op    = MD_NONE;
      flush    = 1'b0;
      rs_data  = '0;
      rt_data  = '0;
      m_hi     = '0;
      m_lo     = '0;
      @(posedge clk);
      #1;
      total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
      total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall got %b want 0", stall_req); end
      total++; if (hi_q !== 32'd0)     begin bad++; $display("FAIL reset_hi got %h want 0", hi_q); end
      total++; if (lo_q !== 32'd0)     begin bad++; $display("FAIL reset_lo got %h want 0", lo_q); end
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_mult_stall();
      int n;
      md_valid = 1'b1;
      md_op    = MD_MULT;
      rs_data  = 32'hFFFF_FFFD;
      rt_data  = 32'd5;
      @(posedge clk);
      #1;
      // Next instruction is MFHI, held by the pipeline while stalled.
      md_op = MD_MFHI;
      n = 0;
      while (stall_req && n < 100) begin
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL mult_busy_during got %b want 1", busy); end
         @(posedge clk);
         #1;
         n++;
      end
      void'(model_apply(MD_MULT, 32'hFFFF_FFFD, 32'd5));
      total++; if (n != 5)               begin bad++; $display("FAIL mult_stall_len got %0d want 5", n); end
      total++; if (busy !== 1'b0)        begin bad++; $display("FAIL mult_busy_end got %b want 0", busy); end
      total++; if (hi_q !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi got %h want FFFFFFFF", hi_q); end
      total++; if (lo_q !== 32'hFFFFFFF1) begin bad++; $display("FAIL mult_lo got %h want FFFFFFF1", lo_q); end
      total++; if (md_rdata !== 32'hFFFFFFFF) begin bad++; $display("FAIL mfhi_after_stall got %h want FFFFFFFF", md_rdata); end
      @(posedge clk);
      #1;
      md_valid = 1'b0;
      md_op    = MD_NONE;
   endtask

   task automatic test_div_cases();
      logic [3:0]  ops [5]  = '{MD_DIVU, MD_DIV, MD_DIV, MD_DIV, MD_DIVU};
      logic [31:0] as  [5]  = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd12345, 32'd5};
      logic [31:0] bs  [5]  = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0};
      logic [31:0] ehi [5]  = '{32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
      logic [31:0] elo [5]  = '{32'd14, 32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
      int cyc;
      for (int i = 0; i < 5; i++) begin
         run_op(ops[i], as[i], bs[i], cyc);
         void'(model_apply(ops[i], as[i], bs[i]));
         total++; if (cyc != DL)      begin bad++; $display("FAIL div%0d_lat got %0d want %0d", i, cyc, DL); end
         total++; if (hi_q !== ehi[i]) begin bad++; $display("FAIL div%0d_hi got %h want %h", i, hi_q, ehi[i]); end
         total++; if (lo_q !== elo[i]) begin bad++; $display("FAIL div%0d_lo got %h want %h", i, lo_q, elo[i]); end
      end
   endtask

   task automatic test_flush();
      int cyc;
      run_op(MD_MTHI, 32'h1234, 32'd0, cyc);
      void'(model_apply(MD_MTHI, 32'h1234, 32'd0));
      total++; if (hi_q !== 32'h1234) begin bad++; $display("FAIL mthi got %h want 1234", hi_q); end
      // Flush on the issue cycle: nothing starts.
      md_valid = 1'b1;
      md_op    = MD_MULT;
      rs_data  = 32'd7;
      rt_data  = 32'd9;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      md_valid = 1'b0;
      md_op    = MD_NONE;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_issue_busy got %b want 0", busy); end
      // Issue, then flush during busy cycle 2.
      md_valid = 1'b1;
      md_op    = MD_MULT;
      @(posedge clk);
      #1;
      md_valid = 1'b0;
      md_op    = MD_NONE;
      @(posedge clk);
      #1;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_busy_c2 got %b want 1", busy); end
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      total++; if (busy !== 1'b0)    begin bad++; $display("FAIL flush_abort_busy got %b want 0", busy); end
      total++; if (hi_q !== m_hi)    begin bad++; $display("FAIL flush_hi got %h want %h", hi_q, m_hi); end
      total++; if (lo_q !== m_lo)    begin bad++; $display("FAIL flush_lo got %h want %h", lo_q, m_lo); end
      md_valid = 1'b1;
      md_op    = MD_MFHI;
      #1;
      total++; if (md_rdata !== 32'h1234) begin bad++; $display("FAIL flush_mfhi got %h want 1234", md_rdata); end
      @(posedge clk);
      #1;
      md_valid = 1'b0;
      md_op    = MD_NONE;
   endtask

   task automatic test_reset_mid();
      int cyc;
      md_valid = 1'b1;
      md_op    = MD_DIV;
      rs_data  = 32'd1000;
      rt_data  = 32'd3;
      @(posedge clk);
      #1;
      md_valid = 1'b0;
      md_op    = MD_NONE;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      #1;
      m_hi = '0;
      m_lo = '0;
      total++; if (busy !== 1'b0)  begin bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
      total++; if (hi_q !== 32'd0) begin bad++; $display("FAIL rstmid_hi got %h want 0", hi_q); end
      total++; if (lo_q !== 32'd0) begin bad++; $display("FAIL rstmid_lo got %h want 0", lo_q); end
      #2;
      reset = 1'b1;
      @(posedge clk);
      #1;
      run_op(MD_DIVU, 32'd9, 32'd3, cyc);
      void'(model_apply(MD_DIVU, 32'd9, 32'd3));
      total++; if (cyc != DL)     begin bad++; $display("FAIL rstmid_divu_lat got %0d want %0d", cyc, DL); end
      total++; if (lo_q !== 32'd3) begin bad++; $display("FAIL rstmid_divu_lo got %h want 3", lo_q); end
      total++; if (hi_q !== 32'd0) begin bad++; $display("FAIL rstmid_divu_hi got %h want 0", hi_q); end
   endtask

   task automatic test_madd();
      int cyc;
      logic want_stall;
`ifdef MD_MADD_EN
      want_stall = 1'b1;
`else
      want_stall = 1'b0;
`endif
      // MADDU presented while a MULT is in flight.
      md_valid = 1'b1;
      md_op    = MD_MULT;
      rs_data  = 32'd2;
      rt_data  = 32'd3;
      @(posedge clk);
      #1;
      md_op = MD_MADDU;
      #1;
      total++; if (stall_req !== want_stall) begin bad++; $display("FAIL madd_stall got %b want %b", stall_req, want_stall); end
      md_valid = 1'b0;
      md_op    = MD_NONE;
      cyc = 0;
      while (busy && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      void'(model_apply(MD_MULT, 32'd2, 32'd3));
      run_op(MD_MTHI, 32'd0, 32'd0, cyc);
      run_op(MD_MTLO, 32'hFFFF_FFFF, 32'd0, cyc);
      void'(model_apply(MD_MTHI, 32'd0, 32'd0));
      void'(model_apply(MD_MTLO, 32'hFFFF_FFFF, 32'd0));
      run_op(MD_MADDU, 32'd1, 32'd1, cyc);
`ifdef MD_MADD_EN
      total++; if (cyc != ML)      begin bad++; $display("FAIL maddu_lat got %0d want %0d", cyc, ML); end
      total++; if (hi_q !== 32'd1) begin bad++; $display("FAIL maddu_hi got %h want 1", hi_q); end
      total++; if (lo_q !== 32'd0) begin bad++; $display("FAIL maddu_lo got %h want 0", lo_q); end
`else
      total++; if (cyc != 0)               begin bad++; $display("FAIL maddu_lat got %0d want 0", cyc); end
      total++; if (hi_q !== 32'd0)         begin bad++; $display("FAIL maddu_hi got %h want 0", hi_q); end
      total++; if (lo_q !== 32'hFFFFFFFF)  begin bad++; $display("FAIL maddu_lo got %h want FFFFFFFF", lo_q); end
`endif
      void'(model_apply(MD_MADDU, 32'd1, 32'd1));
   endtask

   task automatic test_back_to_back();
      logic [31:0] a1, b1, a2, b2;
      int n;
      a1 = $urandom;
      b1 = $urandom;
      a2 = $urandom;
      b2 = $urandom_range(1, 1000);
      md_valid = 1'b1;
      md_op    = MD_MULTU;
      rs_data  = a1;
      rt_data  = b1;
      @(posedge clk);
      #1;
      md_op   = MD_DIVU;
      rs_data = a2;
      rt_data = b2;
      n = 0;
      while (stall_req && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      void'(model_apply(MD_MULTU, a1, b1));
      total++; if (n != ML)       begin bad++; $display("FAIL b2b_stall got %0d want %0d", n, ML); end
      total++; if (hi_q !== m_hi) begin bad++; $display("FAIL b2b_mult_hi got %h want %h", hi_q, m_hi); end
      total++; if (lo_q !== m_lo) begin bad++; $display("FAIL b2b_mult_lo got %h want %h", lo_q, m_lo); end
      // Re-presented DIVU issues on this edge.
      @(posedge clk);
      #1;
      md_valid = 1'b0;
      md_op    = MD_NONE;
      n = 0;
      while (busy && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      void'(model_apply(MD_DIVU, a2, b2));
      total++; if (n != DL)       begin bad++; $display("FAIL b2b_div_lat got %0d want %0d", n, DL); end
      total++; if (hi_q !== m_hi) begin bad++; $display("FAIL b2b_div_hi got %h want %h", hi_q, m_hi); end
      total++; if (lo_q !== m_lo) begin bad++; $display("FAIL b2b_div_lo got %h want %h", lo_q, m_lo); end
   endtask

   task automatic test_random();
      logic [3:0]  pool [8] = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
                                MD_MTHI, MD_MTLO, MD_MFHI, MD_MFLO};
      logic [3:0]  op;
      logic [31:0] a, b, want;
      int cyc, lat;
      for (int i = 0; i < 60; i++) begin
         op = pool[$urandom_range(0, 7)];
         a  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'($urandom);
         b  = ($urandom_range(0, 5) == 0) ? 32'd0 :
              ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
         if (op == MD_MFHI || op == MD_MFLO) begin
            want     = (op == MD_MFHI) ? m_hi : m_lo;
            md_valid = 1'b1;
            md_op    = op;
            #1;
            total++; if (md_rdata !== want) begin bad++; $display("FAIL rnd%0d_mf op=%0d got %h want %h", i, op, md_rdata, want); end
            @(posedge clk);
            #1;
            md_valid = 1'b0;
            md_op    = MD_NONE;
         end else begin
            run_op(op, a, b, cyc);
            lat = model_apply(op, a, b);
            total++; if (cyc != lat)    begin bad++; $display("FAIL rnd%0d_lat op=%0d got %0d want %0d", i, op, cyc, lat); end
            total++; if (hi_q !== m_hi) begin bad++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got %h want %h", i, op, a, b, hi_q, m_hi); end
            total++; if (lo_q !== m_lo) begin bad++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got %h want %h", i, op, a, b, lo_q, m_lo); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_mult_stall();
      test_div_cases();
      test_flush();
      test_reset_mid();
      test_madd();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
